// File: rtl/mem_scan_pkg.sv
// mem_scan_pkg: state encoding and width helpers shared by the scan controller
package mem_scan_pkg;
    localparam int DEF_ADRS_WIDTH = 2;
    localparam int DEF_WORD_WIDTH = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SCAN  = ST_SCAN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;
    function automatic int sum_width(input int aw, input int ww);
        return ww + aw + 1;
    endfunction
    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction
endpackage

// File: rtl/sp_ram_sync.sv
// sp_ram_sync: one write port, one registered read port, no reset on contents
module sp_ram_sync #(
    parameter int ADRS_WIDTH = 2,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADRS_WIDTH-1:0] i_w_addr,
    input  logic [WORD_WIDTH-1:0] i_w_data,
    input  logic [ADRS_WIDTH-1:0] i_r_addr,
    output logic [WORD_WIDTH-1:0] o_r_data
);
    logic [WORD_WIDTH-1:0] r_mem [1<<ADRS_WIDTH];
    // write on enable; read data appears one cycle after the address
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_w_addr] <= i_w_data;
        o_r_data <= r_mem[i_r_addr];
    end
endmodule

// File: rtl/mem_scan_controller.sv
// mem_scan_controller: host-loaded RAM plus an FSM scanning a circular window for sum, max and match count
module mem_scan_controller
    import mem_scan_pkg::*;
#(
    parameter int ADRS_WIDTH = DEF_ADRS_WIDTH,
    parameter int WORD_DEPTH = 1 << ADRS_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [ADRS_WIDTH-1:0]            w_addr,
    input  logic [WORD_WIDTH-1:0]            d_in,
    input  logic                             start,
    input  logic [ADRS_WIDTH-1:0]            base,
    input  logic [ADRS_WIDTH:0]              len,
    input  logic [WORD_WIDTH-1:0]            match_val,
    output logic                             busy,
    output logic                             done,
    output logic [WORD_WIDTH+ADRS_WIDTH:0]   sum_out,
    output logic [WORD_WIDTH-1:0]            max_out,
    output logic [ADRS_WIDTH:0]              match_cnt
);
    localparam int SUM_W = sum_width(ADRS_WIDTH, WORD_WIDTH);
    localparam int CNT_W = cnt_width(ADRS_WIDTH);

    state_t                r_state, w_next;
    logic [ADRS_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      r_rem, w_len_clamped;
    logic                  r_vld;
    logic [WORD_WIDTH-1:0] r_match, w_rdata;
    logic [SUM_W-1:0]      r_sum;
    logic [WORD_WIDTH-1:0] r_max;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_accept, w_wr_en;

    assign w_len_clamped = (len > CNT_W'(WORD_DEPTH)) ? CNT_W'(WORD_DEPTH) : len;
    assign w_accept      = (r_state == IDLE) && start;
    assign w_wr_en       = we && !busy;
    assign sum_out       = r_sum;
    assign max_out       = r_max;
    assign match_cnt     = r_cnt;

    sp_ram_sync #(
        .ADRS_WIDTH(ADRS_WIDTH),
        .WORD_WIDTH(WORD_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_w_addr(w_addr),
        .i_w_data(d_in),
        .i_r_addr(r_addr),
        .o_r_data(w_rdata)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state and status outputs; busy covers everything outside IDLE
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:  if (start) w_next = (w_len_clamped == '0) ? DONE : SCAN;
            SCAN: begin
                busy = 1'b1;
                if (r_rem == CNT_W'(1)) w_next = DRAIN;
            end
            DRAIN: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // address walk, remaining count, read-valid pipe and the three accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_vld   <= 1'b0;
            r_match <= '0;
            r_sum   <= '0;
            r_max   <= '0;
            r_cnt   <= '0;
        end else begin
            r_vld <= (r_state == SCAN);
            if (w_accept) begin
                r_addr  <= base;
                r_rem   <= w_len_clamped;
                r_match <= match_val;
                r_sum   <= '0;
                r_max   <= '0;
                r_cnt   <= '0;
            end else begin
                if (r_state == SCAN) begin
                    r_addr <= r_addr + ADRS_WIDTH'(1);
                    r_rem  <= r_rem - CNT_W'(1);
                end
                if (r_vld) begin
                    r_sum <= r_sum + SUM_W'(w_rdata);
                    r_max <= (w_rdata > r_max) ? w_rdata : r_max;
                    r_cnt <= r_cnt + CNT_W'(w_rdata == r_match);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_scan_controller.sv
// tb_mem_scan_controller: table-driven scans with a scoreboard queue of expected results
module tb_mem_scan_controller;
    logic       clk, rst, we, start;
    logic [1:0] w_addr, base;
    logic [7:0] d_in, match_val;
    logic [2:0] len;
    logic       busy, done;
    logic [9:0] sum_out;
    logic [7:0] max_out;
    logic [2:0] match_cnt;

    typedef struct {
        logic [9:0] sum;
        logic [7:0] mx;
        logic [2:0] cnt;
        int         lat;
    } exp_t;

    typedef struct {
        logic [1:0] b;
        logic [2:0] l;
        logic [7:0] mv;
        exp_t       e;
    } vec_t;

    vec_t       tbl [8];
    exp_t       sb [$];
    logic [7:0] m [4];
    int         n_vec = 0;
    int         n_bad = 0;

    mem_scan_controller dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .w_addr   (w_addr),
        .d_in     (d_in),
        .start    (start),
        .base     (base),
        .len      (len),
        .match_val(match_val),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .max_out  (max_out),
        .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        we = 1'b1;
        w_addr = a;
        d_in = d;
        tick();
        we = 1'b0;
        m[a] = d;
    endtask

    function automatic exp_t model(input logic [1:0] b, input logic [2:0] l, input logic [7:0] mv);
        exp_t e;
        int   n;
        n = (l > 3'd4) ? 4 : int'(l);
        e.sum = '0;
        e.mx = '0;
        e.cnt = '0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] v;
            v = m[(int'(b) + i) % 4];
            e.sum = e.sum + 10'(v);
            if (v > e.mx) e.mx = v;
            if (v == mv) e.cnt = e.cnt + 3'd1;
        end
        e.lat = (n == 0) ? 1 : n + 2;
        return e;
    endfunction

    // wmode: 0 none, 1 write in the start cycle, 2 write attempted in cycle 2 while busy
    task automatic run_scan(input logic [1:0] b, input logic [2:0] l, input logic [7:0] mv,
                            input exp_t e, input int wmode, input logic [1:0] wa, input logic [7:0] wd);
        exp_t x;
        int   k;
        bit   got;
        sb.push_back(e);
        base = b;
        len = l;
        match_val = mv;
        start = 1'b1;
        if (wmode == 1) begin
            we = 1'b1;
            w_addr = wa;
            d_in = wd;
            m[wa] = wd;
        end
        tick();
        start = 1'b0;
        we = 1'b0;
        k = 1;
        got = 1'b0;
        chk("busy_cycle1", busy, 1);
        while (k <= 20 && !got) begin
            if (done) got = 1'b1;
            else begin
                if (wmode == 2 && k == 2) begin
                    we = 1'b1;
                    w_addr = wa;
                    d_in = wd;
                end else we = 1'b0;
                tick();
                k++;
            end
        end
        we = 1'b0;
        x = sb.pop_front();
        if (!got) chk("done_timeout", 0, 1);
        else begin
            chk("done_cycle", k, x.lat);
            chk("sum_out", sum_out, x.sum);
            chk("max_out", max_out, x.mx);
            chk("match_cnt", match_cnt, x.cnt);
            chk("busy_at_done", busy, 1);
        end
        tick();
        chk("done_one_cycle", done, 0);
        chk("sum_hold", sum_out, x.sum);
    endtask

    initial begin
        int ndone;
        tbl[0] = '{2'd0, 3'd4, 8'h22, '{10'h0AA, 8'h44, 3'd1, 6}};
        tbl[1] = '{2'd3, 3'd2, 8'h11, '{10'h055, 8'h44, 3'd1, 4}};
        tbl[2] = '{2'd0, 3'd0, 8'h00, '{10'h000, 8'h00, 3'd0, 1}};
        tbl[3] = '{2'd0, 3'd7, 8'h22, '{10'h0AA, 8'h44, 3'd1, 6}};
        tbl[4] = '{2'd1, 3'd1, 8'h22, '{10'h022, 8'h22, 3'd1, 3}};
        tbl[5] = '{2'd2, 3'd3, 8'h55, '{10'h088, 8'h44, 3'd0, 5}};
        tbl[6] = '{2'd1, 3'd4, 8'h44, '{10'h0AA, 8'h44, 3'd1, 6}};
        tbl[7] = '{2'd3, 3'd5, 8'h33, '{10'h0AA, 8'h44, 3'd1, 6}};
        rst = 1'b1;
        we = 1'b0;
        start = 1'b0;
        w_addr = '0;
        d_in = '0;
        base = '0;
        len = '0;
        match_val = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_max", max_out, 0);
        chk("rst_cnt", match_cnt, 0);
        wr(2'd0, 8'h11);
        wr(2'd1, 8'h22);
        wr(2'd2, 8'h33);
        wr(2'd3, 8'h44);
        for (int i = 0; i < 8; i++) run_scan(tbl[i].b, tbl[i].l, tbl[i].mv, tbl[i].e, 0, 2'd0, 8'h00);
        run_scan(2'd0, 3'd4, 8'h22, '{10'h0AA, 8'h44, 3'd1, 6}, 2, 2'd0, 8'hFF);
        run_scan(2'd0, 3'd4, 8'h11, '{10'h0AA, 8'h44, 3'd1, 6}, 0, 2'd0, 8'h00);
        run_scan(2'd0, 3'd4, 8'h77, '{10'h0FF, 8'h77, 3'd1, 6}, 1, 2'd1, 8'h77);
        wr(2'd1, 8'h22);
        base = 2'd0;
        len = 3'd4;
        match_val = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sum", sum_out, 0);
        chk("midrst_max", max_out, 0);
        chk("midrst_cnt", match_cnt, 0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("midrst_no_done", ndone, 0);
        run_scan(tbl[0].b, tbl[0].l, tbl[0].mv, tbl[0].e, 0, 2'd0, 8'h00);
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 4; a++) wr(2'(a), 8'($urandom));
            for (int s = 0; s < 3; s++) begin
                logic [1:0] b;
                logic [2:0] l;
                logic [7:0] mv;
                b = 2'($urandom_range(0, 3));
                l = 3'($urandom_range(0, 7));
                mv = (s == 0) ? m[b] : 8'($urandom);
                run_scan(b, l, mv, model(b, l, mv), 0, 2'd0, 8'h00);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
